// File: rtl/debounce_step.sv
// Push-button conditioner: synchroniser, dwell-counted debounce FSM, and
// registered level plus single-cycle rise/fall pulses.
module debounce_step #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          count, count_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   bs;
    logic                   level_nxt, rise_nxt, fall_nxt;

    assign bs = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], btn};
    end

    // State register, with outputs registered alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOW;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            S_LOW: begin
                count_nxt = '0;
                if (bs) begin
                    state_nxt = S_WAIT_HIGH;
                    count_nxt = CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (!bs) begin
                    state_nxt = S_LOW;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt = S_HIGH;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            S_HIGH: begin
                count_nxt = '0;
                if (!bs) begin
                    state_nxt = S_WAIT_LOW;
                    count_nxt = CW'(1);
                end
            end
            S_WAIT_LOW: begin
                if (bs) begin
                    state_nxt = S_HIGH;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt = S_LOW;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = S_LOW;
                count_nxt = '0;
            end
        endcase
    end

    // Pulses fire only on completed dwells, never on bounce returns
    always_comb begin
        level_nxt = (state_nxt == S_HIGH) || (state_nxt == S_WAIT_LOW);
        rise_nxt  = (state == S_WAIT_HIGH) && (state_nxt == S_HIGH);
        fall_nxt  = (state == S_WAIT_LOW)  && (state_nxt == S_LOW);
    end
endmodule

// File: tb/tb_debounce_step.sv
// Directed bench for debounce_step with defaults (2 sync stages, 4 dwell cycles).
module tb_debounce_step;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn = 1'b0;
    logic level, rise, fall;

    int checks = 0;
    int failures = 0;

    logic [1:0] step_cnt = 2'd0;
    logic       step_clr = 1'b0;

    debounce_step dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    // Downstream 2-bit step counter driven by rise
    always @(posedge clk) begin
        if (step_clr)  step_cnt <= 2'd0;
        else if (rise) step_cnt <= step_cnt + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge, then sit on the falling edge for driving/sampling
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_out(input string tag, input int k, input logic l, input logic r, input logic f);
        chk($sformatf("%s_level_e%0d", tag, k), 32'(level), 32'(l));
        chk($sformatf("%s_rise_e%0d",  tag, k), 32'(rise),  32'(r));
        chk($sformatf("%s_fall_e%0d",  tag, k), 32'(fall),  32'(f));
    endtask

    logic bounce_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset asserted between edges takes effect immediately
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_out("rst_async", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_out("rst_idle", k, 1'b0, 1'b0, 1'b0);
        end

        // Clean press: level/rise after edge 6
        btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_out("press", k, k >= 6, k == 6, 1'b0);
        end
        btn = 1'b0;
        run(12);
        chk("press_settle_level", 32'(level), 32'd0);

        // Bounce pattern then steady high: rise after edge 11
        for (int k = 1; k <= 14; k++) begin
            btn = (k <= 6) ? bounce_pat[k-1] : 1'b1;
            tick();
            chk_out("bounce", k, k >= 11, k == 11, 1'b0);
        end
        btn = 1'b0;
        run(12);
        chk("bounce_settle_level", 32'(level), 32'd0);

        // 3-cycle pulse is shorter than the dwell: no change at all
        for (int k = 1; k <= 12; k++) begin
            btn = (k <= 3);
            tick();
            chk_out("short", k, 1'b0, 1'b0, 1'b0);
        end

        // Press 20 cycles, release before edge 21: fall after edge 26
        for (int k = 1; k <= 30; k++) begin
            btn = (k <= 20);
            tick();
            chk_out("pair", k, (k >= 6) && (k < 26), k == 6, k == 26);
        end

        // Reset after edge 4 of a press, release with btn held high
        btn = 1'b1;
        run(4);
        reset = 1'b1;
        #1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_rise",  32'(rise),  32'd0);
        @(negedge clk);
        run(2);
        chk_out("midrst_hold", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_out("midrst_rel", k, k >= 6, k == 6, 1'b0);
        end
        btn = 1'b0;
        run(12);

        // Five clean presses stepping the counter
        step_clr = 1'b1;
        tick();
        step_clr = 1'b0;
        chk("cnt_init", 32'(step_cnt), 32'd0);
        for (int p = 0; p < 5; p++) begin
            btn = 1'b1;
            run(10);
            btn = 1'b0;
            run(10);
            chk($sformatf("cnt_press%0d", p + 1), 32'(step_cnt), 32'(cnt_exp[p]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
